// File: rtl/noc_pkg.sv
// Shared constants for the NoC flit sinks: flit code words, packet type
// encodings, fixed field widths and err_code bit positions.
package noc_pkg;

  // Fixed-width flit fields; the parameterised ones come from the instantiating module
  localparam int CODE_W = 4;
  localparam int TYPE_W = 3;
  localparam int LEN_W  = 8;
  localparam int ERR_W  = 4;
  localparam int CNT_W  = 9;

  // Framing code words
  localparam logic [CODE_W-1:0] CODE_HEAD_H = 4'h5;
  localparam logic [CODE_W-1:0] CODE_HEAD_E = 4'hA;
  localparam logic [CODE_W-1:0] CODE_TAIL_H = 4'h0;
  localparam logic [CODE_W-1:0] CODE_TAIL_E = 4'hF;

  // Packet types
  localparam logic [TYPE_W-1:0] TYPE_RD_DATA = 3'b001;
  localparam logic [TYPE_W-1:0] TYPE_RD_REQ  = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_BRESP   = 3'b011;
  localparam logic [TYPE_W-1:0] TYPE_WRITE   = 3'b100;

  // err_code bit positions: {LEN, TAIL, HEAD, DEST}
  localparam int ERR_DEST = 0;
  localparam int ERR_HEAD = 1;
  localparam int ERR_TAIL = 2;
  localparam int ERR_LEN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CLOSE   = 2'd2
  } rcv_state_e;

  // Number of data flits a packet of this type/length must carry.
  // Request and response packets carry a single flit regardless of LEN.
  function automatic logic [CNT_W-1:0] expected_beats(input logic [TYPE_W-1:0] typ,
                                                      input logic [LEN_W-1:0]  len);
    logic [CNT_W-1:0] n;
    n = 9'd1;
    if (typ == TYPE_WRITE || typ == TYPE_RD_DATA) begin
      n = {1'b0, len} + 9'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/noc_flit_decode.sv
// Combinational flit field slicer with head/tail code-word check.
// Layout from the MSB down: CODE_H, SRC, DST, TYPE, ORDER, LEN, ADDR, CODE_E, pad.
module noc_flit_decode
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH     = 128,
  parameter int ID_WIDTH       = 4,
  parameter int VIRTUAL_CH_NUM = 16,
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]     flit_i,
  output logic [ID_WIDTH-1:0]       src_o,
  output logic [ID_WIDTH-1:0]       dst_o,
  output logic [TYPE_W-1:0]         type_o,
  output logic [VIRTUAL_CH_NUM-1:0] order_o,
  output logic [LEN_W-1:0]          len_o,
  output logic [AXI_ADDR_WIDTH-1:0] addr_o,
  output logic                      head_ok_o,
  output logic                      tail_ok_o
);

  localparam int CODE_H_LSB = DATA_WIDTH - CODE_W;
  localparam int SRC_LSB    = CODE_H_LSB - ID_WIDTH;
  localparam int DST_LSB    = SRC_LSB - ID_WIDTH;
  localparam int TYPE_LSB   = DST_LSB - TYPE_W;
  localparam int ORDER_LSB  = TYPE_LSB - VIRTUAL_CH_NUM;
  localparam int LEN_LSB    = ORDER_LSB - LEN_W;
  localparam int ADDR_LSB   = LEN_LSB - AXI_ADDR_WIDTH;
  localparam int CODE_E_LSB = ADDR_LSB - CODE_W;

  logic [CODE_W-1:0] code_h;
  logic [CODE_W-1:0] code_e;
  logic              unused_pad;

  assign code_h  = flit_i[CODE_H_LSB +: CODE_W];
  assign src_o   = flit_i[SRC_LSB    +: ID_WIDTH];
  assign dst_o   = flit_i[DST_LSB    +: ID_WIDTH];
  assign type_o  = flit_i[TYPE_LSB   +: TYPE_W];
  assign order_o = flit_i[ORDER_LSB  +: VIRTUAL_CH_NUM];
  assign len_o   = flit_i[LEN_LSB    +: LEN_W];
  assign addr_o  = flit_i[ADDR_LSB   +: AXI_ADDR_WIDTH];
  assign code_e  = flit_i[CODE_E_LSB +: CODE_W];

  // Pad bits carry no information
  assign unused_pad = ^flit_i[CODE_E_LSB-1:0];

  assign head_ok_o = (code_h == CODE_HEAD_H) && (code_e == CODE_HEAD_E);
  assign tail_ok_o = (code_h == CODE_TAIL_H) && (code_e == CODE_TAIL_E);

endmodule

// File: rtl/noc_pkt_receiver.sv
// NoC packet sink: validates head/data/tail framing, forwards data flits as a
// payload stream, latches head fields and pulses done/error once per packet.
// Optional build macro NOC_RCV_STATS_EN adds saturating packet/error counters.
module noc_pkt_receiver
  import noc_pkg::*;
#(
  parameter int                  DATA_WIDTH     = 128,
  parameter int                  ID_WIDTH       = 4,
  parameter int                  VIRTUAL_CH_NUM = 16,
  parameter int                  AXI_ADDR_WIDTH = 32,
  parameter logic [ID_WIDTH-1:0] LOCAL_ID       = 4'hF
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic [DATA_WIDTH:0]       noc_data,
  input  logic                      s_is_head,
  input  logic                      s_is_tail,
  output logic                      rcv_busy,
  output logic [DATA_WIDTH-1:0]     pld_data,
  output logic                      pld_valid,
  output logic                      pld_last,
  input  logic                      pld_ready,
  output logic [ID_WIDTH-1:0]       pkt_src,
  output logic [TYPE_W-1:0]         pkt_type,
  output logic [VIRTUAL_CH_NUM-1:0] pkt_order,
  output logic [LEN_W-1:0]          pkt_len,
  output logic [AXI_ADDR_WIDTH-1:0] pkt_addr,
  output logic                      pkt_done,
  output logic                      pkt_err,
  output logic [ERR_W-1:0]          err_code
`ifdef NOC_RCV_STATS_EN
  ,
  output logic [15:0]               stat_pkt_cnt,
  output logic [15:0]               stat_err_cnt
`endif
);

  rcv_state_e                state_q;
  logic [DATA_WIDTH-1:0]     pld_data_q;
  logic                      pld_valid_q;
  logic                      pld_last_q;
  logic [ID_WIDTH-1:0]       src_q;
  logic [ID_WIDTH-1:0]       dst_q;
  logic [TYPE_W-1:0]         type_q;
  logic [VIRTUAL_CH_NUM-1:0] order_q;
  logic [LEN_W-1:0]          len_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]          exp_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      over_q;
  logic                      dest_err_q;
  logic                      tail_err_q;
  logic                      pkt_done_q;
  logic                      pkt_err_q;
  logic [ERR_W-1:0]          err_code_q;

  logic [ID_WIDTH-1:0]       dec_src;
  logic [ID_WIDTH-1:0]       dec_dst;
  logic [TYPE_W-1:0]         dec_type;
  logic [VIRTUAL_CH_NUM-1:0] dec_order;
  logic [LEN_W-1:0]          dec_len;
  logic [AXI_ADDR_WIDTH-1:0] dec_addr;
  logic                      dec_head_ok;
  logic                      dec_tail_ok;

  logic                      xfer;
  logic                      head_x;
  logic                      tail_x;
  logic                      data_x;
  logic                      tail_mismatch;
  logic [ERR_W-1:0]          close_err;

  noc_flit_decode #(
    .DATA_WIDTH     (DATA_WIDTH),
    .ID_WIDTH       (ID_WIDTH),
    .VIRTUAL_CH_NUM (VIRTUAL_CH_NUM),
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH)
  ) u_decode (
    .flit_i    (noc_data[DATA_WIDTH-1:0]),
    .src_o     (dec_src),
    .dst_o     (dec_dst),
    .type_o    (dec_type),
    .order_o   (dec_order),
    .len_o     (dec_len),
    .addr_o    (dec_addr),
    .head_ok_o (dec_head_ok),
    .tail_ok_o (dec_tail_ok)
  );

  // Stall the sender while closing a packet or while a payload beat is blocked
  assign rcv_busy = (state_q == ST_CLOSE) |
                    ((state_q == ST_PAYLOAD) & pld_valid_q & ~pld_ready);

  // A flit moves only when valid and not back-pressured; head wins over tail
  assign xfer   = noc_data[DATA_WIDTH] & ~rcv_busy;
  assign head_x = xfer & s_is_head;
  assign tail_x = xfer & ~s_is_head & s_is_tail;
  assign data_x = xfer & ~s_is_head & ~s_is_tail;

  assign tail_mismatch = ~dec_tail_ok | (dec_src != src_q) | (dec_dst != dst_q) |
                         (dec_type != type_q) | (dec_len != len_q);

  // Close-time error vector; HEAD errors are reported immediately, never here
  always_comb begin
    close_err           = '0;
    close_err[ERR_DEST] = dest_err_q;
    close_err[ERR_TAIL] = tail_err_q;
    close_err[ERR_LEN]  = over_q | (cnt_q != exp_q);
  end

  // Receive FSM with registered payload, head fields and status pulses
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      state_q     <= ST_IDLE;
      pld_data_q  <= '0;
      pld_valid_q <= 1'b0;
      pld_last_q  <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      type_q      <= '0;
      order_q     <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
      over_q      <= 1'b0;
      dest_err_q  <= 1'b0;
      tail_err_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      pkt_err_q  <= 1'b0;
      err_code_q <= '0;

      if (pld_valid_q && pld_ready) begin
        pld_valid_q <= 1'b0;
        pld_last_q  <= 1'b0;
      end

      // A well-formed head always opens a fresh packet, even one cutting in mid-payload
      if (head_x && dec_head_ok) begin
        src_q      <= dec_src;
        dst_q      <= dec_dst;
        type_q     <= dec_type;
        order_q    <= dec_order;
        len_q      <= dec_len;
        addr_q     <= dec_addr;
        exp_q      <= expected_beats(dec_type, dec_len);
        cnt_q      <= '0;
        over_q     <= 1'b0;
        tail_err_q <= 1'b0;
        dest_err_q <= (dec_dst != LOCAL_ID);
      end

      case (state_q)
        ST_IDLE: begin
          if (head_x) begin
            if (dec_head_ok) begin
              state_q <= ST_PAYLOAD;
            end else begin
              pkt_err_q            <= 1'b1;
              err_code_q[ERR_HEAD] <= 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          if (head_x) begin
            pkt_err_q            <= 1'b1;
            err_code_q[ERR_HEAD] <= 1'b1;
            if (!dec_head_ok) state_q <= ST_IDLE;
          end else if (data_x) begin
            if (cnt_q < exp_q) begin
              pld_valid_q <= 1'b1;
              pld_data_q  <= noc_data[DATA_WIDTH-1:0];
              pld_last_q  <= (cnt_q == exp_q - 9'd1);
              cnt_q       <= cnt_q + 9'd1;
            end else begin
              over_q <= 1'b1;
            end
          end else if (tail_x) begin
            tail_err_q <= tail_mismatch;
            state_q    <= ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          if (|close_err) begin
            pkt_err_q  <= 1'b1;
            err_code_q <= close_err;
          end else begin
            pkt_done_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pld_data  = pld_data_q;
  assign pld_valid = pld_valid_q;
  assign pld_last  = pld_last_q;
  assign pkt_src   = src_q;
  assign pkt_type  = type_q;
  assign pkt_order = order_q;
  assign pkt_len   = len_q;
  assign pkt_addr  = addr_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;

`ifdef NOC_RCV_STATS_EN
  logic [15:0] stat_pkt_q;
  logic [15:0] stat_pkt_d;
  logic [15:0] stat_err_q;
  logic [15:0] stat_err_d;

  // Saturating next-state for the packet and error counters
  always_comb begin
    stat_pkt_d = stat_pkt_q;
    stat_err_d = stat_err_q;
    if (pkt_done_q && (stat_pkt_q != 16'hFFFF)) stat_pkt_d = stat_pkt_q + 16'd1;
    if (pkt_err_q  && (stat_err_q != 16'hFFFF)) stat_err_d = stat_err_q + 16'd1;
  end

  // Statistics registers
  always_ff @(posedge noc_clk) begin
    if (!noc_rst_n) begin
      stat_pkt_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_pkt_q <= stat_pkt_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_pkt_cnt = stat_pkt_q;
  assign stat_err_cnt = stat_err_q;
`endif

endmodule
